// File: rtl/usrt_pkg.sv
// Shared USRT definitions: transmit sequencer states, common baud divisors
// (cycles per bit at the nominal system clock) and default widths.
package usrt_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_e;

    localparam int unsigned BAUD_W_DEF  = 14;
    localparam int unsigned DATA_W_DEF  = 8;

    localparam int unsigned BAUD_1200   = 8333;
    localparam int unsigned BAUD_2400   = 4166;
    localparam int unsigned BAUD_4800   = 2083;
    localparam int unsigned BAUD_9600   = 1041;
    localparam int unsigned BAUD_19200  = 520;
    localparam int unsigned BAUD_38400  = 260;
    localparam int unsigned BAUD_57600  = 173;
    localparam int unsigned BAUD_115200 = 86;

endpackage

// File: rtl/usrt_baud_timer.sv
// Loadable bit-period down-counter. Load with period P; tick_o is high on the
// P-th cycle after the load. tick_next_o flags that the following cycle ticks.
module usrt_baud_timer #(
    parameter int unsigned BAUD_W = 14
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic [BAUD_W-1:0] period_i,
    output logic              tick_o,
    output logic              tick_next_o
);

    logic [BAUD_W-1:0] cnt_q, cnt_d;

    // period_i is never zero: callers map a zero divisor to one cycle per bit.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = period_i - BAUD_W'(1);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - BAUD_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o      = (cnt_q == '0);
    assign tick_next_o = (cnt_d == '0);

endmodule

// File: rtl/usrt_tx_ctrl.sv
// USRT transmit frame sequencer: start bit, LSB-first data, optional even
// parity, stop bit. Divisor and parity enable are latched at byte acceptance.
module usrt_tx_ctrl
    import usrt_pkg::*;
#(
    parameter int unsigned BAUD_W = BAUD_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              i_Pclk,
    input  logic              i_Preset,
    input  logic [BAUD_W-1:0] i_Baud,
    input  logic              i_ParityEn,
    input  logic              i_TxValid,
    input  logic [DATA_W-1:0] i_TxData,
    output logic              o_TxReady,
    output logic              o_Tx,
    output logic              o_Busy,
    output logic              o_Done
);

    localparam int unsigned      IDX_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

    tx_state_e         state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [BAUD_W-1:0] period_q, period_d;
    logic              par_en_q, par_en_d;
    logic              par_bit_q, par_bit_d;
    logic              tx_q, tx_d;
    logic              ready_q, ready_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              accept;
    logic              tmr_load;
    logic              tick;
    logic              tick_next;

    assign accept = i_TxValid & ready_q;

    usrt_baud_timer #(
        .BAUD_W (BAUD_W)
    ) u_timer (
        .clk_i       (i_Pclk),
        .rst_i       (i_Preset),
        .load_i      (tmr_load),
        .period_i    (period_d),
        .tick_o      (tick),
        .tick_next_o (tick_next)
    );

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        data_d    = data_q;
        period_d  = period_q;
        par_en_d  = par_en_q;
        par_bit_d = par_bit_q;
        tmr_load  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d   = START;
                    data_d    = i_TxData;
                    par_en_d  = i_ParityEn;
                    par_bit_d = ^i_TxData;
                    period_d  = (i_Baud == '0) ? BAUD_W'(1) : i_Baud;
                    tmr_load  = 1'b1;
                end
            end
            START: begin
                if (tick) begin
                    state_d  = DATA;
                    idx_d    = '0;
                    tmr_load = 1'b1;
                end
            end
            DATA: begin
                if (tick) begin
                    tmr_load = 1'b1;
                    if (idx_q == LAST_IDX) begin
                        state_d = par_en_q ? PARITY : STOP;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            PARITY: begin
                if (tick) begin
                    state_d  = STOP;
                    tmr_load = 1'b1;
                end
            end
            STOP: begin
                if (tick) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from next-state values so they line up with the state.
    always_comb begin
        tx_d    = 1'b1;
        ready_d = (state_d == IDLE);
        busy_d  = (state_d != IDLE);
        done_d  = (state_d == STOP) && tick_next;
        unique case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = data_d[idx_d];
            PARITY:  tx_d = par_bit_d;
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge i_Pclk or posedge i_Preset) begin
        if (i_Preset) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            data_q    <= '0;
            period_q  <= '0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            tx_q      <= 1'b1;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            data_q    <= data_d;
            period_q  <= period_d;
            par_en_q  <= par_en_d;
            par_bit_q <= par_bit_d;
            tx_q      <= tx_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign o_Tx      = tx_q;
    assign o_TxReady = ready_q;
    assign o_Busy    = busy_q;
    assign o_Done    = done_q;

endmodule
